// File: rtl/gpio_pkg.sv
// Register map, reset values and address decode helper shared by the GPIO port
// and its bench.
package gpio_pkg;

   localparam int GPIO_ADDR_W = 3;

   localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_DIR     = 3'd0;
   localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_OUT     = 3'd1;
   localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_IN      = 3'd2;
   localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_RISE_EN = 3'd3;
   localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_FALL_EN = 3'd4;
   localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_STAT    = 3'd5;

   localparam logic [GPIO_ADDR_W:0] GPIO_REG_COUNT = 4'd6;

   // Every register bit, synchroniser flop and edge history bit resets low.
   localparam logic GPIO_RST_BIT = 1'b0;

   // Plain read/write configuration registers; IN is read-only, STAT is W1C
   // and handled separately, 6-7 are unmapped.
   function automatic logic gpio_reg_writable(input logic [GPIO_ADDR_W-1:0] addr);
      return (addr == GPIO_REG_DIR)     ||
             (addr == GPIO_REG_OUT)     ||
             (addr == GPIO_REG_RISE_EN) ||
             (addr == GPIO_REG_FALL_EN);
   endfunction

endpackage

// File: rtl/gpio_pin_cell.sv
// One GPIO pin: tri-state driver, input synchroniser, optional debounce filter
// (enabled by the GPIO_DEBOUNCE_EN macro) and enable-masked edge detection.
module gpio_pin_cell
   import gpio_pkg::*;
#(
   parameter int SYNC_STAGES = 2
`ifdef GPIO_DEBOUNCE_EN
   ,
   parameter int DEB_CYCLES  = 4
`endif
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic dir_bit,
   input  logic out_bit,
   input  logic rise_en,
   input  logic fall_en,
   inout  logic io_pin,
   output logic filt,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_p;
   logic                   prev_p;

   // The pin reads back through the synchroniser even while this cell drives it.
   assign io_pin = dir_bit ? out_bit : 1'bz;

   // ---- stage boundary: pin -> synchroniser chain ----
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_p <= {SYNC_STAGES{GPIO_RST_BIT}};
      end else begin
         sync_p <= {sync_p[SYNC_STAGES-2:0], io_pin};
      end
   end

`ifdef GPIO_DEBOUNCE_EN
   localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

   logic [CNT_W-1:0] deb_cnt;
   logic             deb_filt;

   // ---- stage boundary: synchroniser -> debounced level ----
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         deb_cnt  <= '0;
         deb_filt <= GPIO_RST_BIT;
      end else if (sync_p[SYNC_STAGES-1] != deb_filt) begin
         if (deb_cnt == CNT_W'(DEB_CYCLES - 1)) begin
            deb_filt <= sync_p[SYNC_STAGES-1];
            deb_cnt  <= '0;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end
      end else begin
         // Any return to the filtered level restarts the stability window.
         deb_cnt <= '0;
      end
   end

   assign filt = deb_filt;
`else
   assign filt = sync_p[SYNC_STAGES-1];
`endif

   // ---- stage boundary: filtered level -> edge history ----
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         prev_p <= GPIO_RST_BIT;
      end else begin
         prev_p <= filt;
      end
   end

   assign rise = filt & ~prev_p & rise_en;
   assign fall = ~filt & prev_p & fall_en;

endmodule

// File: rtl/gpio_port_irq.sv
// GPIO port with per-pin direction, edge-capture status (W1C) and a level IRQ.
// Optional input debounce is built in when GPIO_DEBOUNCE_EN is defined.
module gpio_port_irq
   import gpio_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int DEB_CYCLES  = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_we,
   input  logic [GPIO_ADDR_W-1:0] i_addr,
   input  logic [WIDTH-1:0]       i_wdata,
   output logic [WIDTH-1:0]       o_rdata,
   output logic                   o_irq,
   inout  logic [WIDTH-1:0]       io_pins
);

   if ((WIDTH < 1) || (WIDTH > 32)) begin : g_bad_width
      $error("gpio_port_irq: WIDTH must be in 1..32");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("gpio_port_irq: SYNC_STAGES must be >= 2");
   end
   if (DEB_CYCLES < 2) begin : g_bad_deb
      $error("gpio_port_irq: DEB_CYCLES must be >= 2");
   end

   logic [WIDTH-1:0] dir_r;
   logic [WIDTH-1:0] out_r;
   logic [WIDTH-1:0] rise_en_r;
   logic [WIDTH-1:0] fall_en_r;
   logic [WIDTH-1:0] stat_r;

   logic [WIDTH-1:0] filt;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] stat_clr;
   logic [WIDTH-1:0] rdata_nxt;
   logic             cfg_we;

   for (genvar g = 0; g < WIDTH; g++) begin : g_pin
      gpio_pin_cell #(
         .SYNC_STAGES (SYNC_STAGES)
`ifdef GPIO_DEBOUNCE_EN
         ,
         .DEB_CYCLES  (DEB_CYCLES)
`endif
      ) u_cell (
         .i_clk   (i_clk),
         .i_rst_n (i_rst_n),
         .dir_bit (dir_r[g]),
         .out_bit (out_r[g]),
         .rise_en (rise_en_r[g]),
         .fall_en (fall_en_r[g]),
         .io_pin  (io_pins[g]),
         .filt    (filt[g]),
         .rise    (rise[g]),
         .fall    (fall[g])
      );
   end

   assign cfg_we = i_we && gpio_reg_writable(i_addr);

   always_comb begin
      stat_clr = '0;
      if (i_we && (i_addr == GPIO_REG_STAT)) begin
         stat_clr = i_wdata;
      end
   end

   // ---- stage boundary: bus write -> configuration registers ----
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         dir_r     <= {WIDTH{GPIO_RST_BIT}};
         out_r     <= {WIDTH{GPIO_RST_BIT}};
         rise_en_r <= {WIDTH{GPIO_RST_BIT}};
         fall_en_r <= {WIDTH{GPIO_RST_BIT}};
      end else if (cfg_we) begin
         case (i_addr)
            GPIO_REG_DIR:     dir_r     <= i_wdata;
            GPIO_REG_OUT:     out_r     <= i_wdata;
            GPIO_REG_RISE_EN: rise_en_r <= i_wdata;
            GPIO_REG_FALL_EN: fall_en_r <= i_wdata;
            default: ;
         endcase
      end
   end

   // ---- stage boundary: edge pulses -> sticky status ----
   // A new edge in the same cycle as its W1C wins, so no event is lost.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stat_r <= {WIDTH{GPIO_RST_BIT}};
      end else begin
         stat_r <= (stat_r & ~stat_clr) | rise | fall;
      end
   end

   always_comb begin
      rdata_nxt = '0;
      case (i_addr)
         GPIO_REG_DIR:     rdata_nxt = dir_r;
         GPIO_REG_OUT:     rdata_nxt = out_r;
         GPIO_REG_IN:      rdata_nxt = filt;
         GPIO_REG_RISE_EN: rdata_nxt = rise_en_r;
         GPIO_REG_FALL_EN: rdata_nxt = fall_en_r;
         GPIO_REG_STAT:    rdata_nxt = stat_r;
         default:          rdata_nxt = '0;
      endcase
   end

   // ---- stage boundary: read mux and status -> registered outputs ----
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_rdata <= {WIDTH{GPIO_RST_BIT}};
         o_irq   <= GPIO_RST_BIT;
      end else begin
         o_rdata <= rdata_nxt;
         o_irq   <= |stat_r;
      end
   end

endmodule

// File: tb/tb_gpio_port_irq.sv
// Scoreboard bench for gpio_port_irq: stimulus queues expectations, a monitor
// compares o_rdata / o_irq / pins one clock after each check is issued.
module tb_gpio_port_irq;
   import gpio_pkg::*;

   localparam int W = 16;
`ifdef GPIO_DEBOUNCE_EN
   localparam int DEB = 4;
`else
   localparam int DEB = 0;
`endif

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         we    = 1'b0;
   logic [2:0]   addr  = '0;
   logic [W-1:0] wdata = '0;
   logic [W-1:0] rdata;
   logic         irq;
   wire  [W-1:0] pins;
   logic [W-1:0] ext_oe  = '1;
   logic [W-1:0] ext_val = '0;

   for (genvar i = 0; i < W; i++) begin : g_ext
      assign pins[i] = ext_oe[i] ? ext_val[i] : 1'bz;
   end

   always #5 clk = ~clk;

   gpio_port_irq #(.WIDTH(W), .SYNC_STAGES(2), .DEB_CYCLES(4)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_we    (we),
      .i_addr  (addr),
      .i_wdata (wdata),
      .o_rdata (rdata),
      .o_irq   (irq),
      .io_pins (pins)
   );

   typedef struct {
      logic         do_rd;
      logic [W-1:0] rd_exp;
      logic         do_irq;
      logic         irq_exp;
      logic         do_pin;
      logic [W-1:0] pin_exp;
      logic [W-1:0] pin_mask;
      string        name;
   } chk_t;

   chk_t exp_q[$];
   logic chk_req = 1'b0;
   logic chk_vld = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always @(posedge clk) chk_vld <= chk_req;

   // Monitor: one expectation per check cycle, popped after the clock edge.
   always @(negedge clk) begin
      chk_t e;
      if (chk_vld) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_underflow: no expectation queued");
         end else begin
            e = exp_q.pop_front();
            if (e.do_rd) begin
               n_tests++;
               if (rdata !== e.rd_exp) begin
                  n_fail++;
                  $display("FAIL %s rdata: got %h required %h", e.name, rdata, e.rd_exp);
               end
            end
            if (e.do_irq) begin
               n_tests++;
               if (irq !== e.irq_exp) begin
                  n_fail++;
                  $display("FAIL %s irq: got %b required %b", e.name, irq, e.irq_exp);
               end
            end
            if (e.do_pin) begin
               n_tests++;
               if ((pins & e.pin_mask) !== (e.pin_exp & e.pin_mask)) begin
                  n_fail++;
                  $display("FAIL %s pins: got %h required %h (mask %h)", e.name,
                           pins & e.pin_mask, e.pin_exp & e.pin_mask, e.pin_mask);
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      @(negedge clk);
      we    = 1'b0;
   endtask

   task automatic chk(input logic do_rd, input logic [2:0] a, input logic [W-1:0] rd_exp,
                      input logic do_irq, input logic irq_exp, input string name);
      chk_t e;
      e.do_rd    = do_rd;
      e.rd_exp   = rd_exp;
      e.do_irq   = do_irq;
      e.irq_exp  = irq_exp;
      e.do_pin   = 1'b0;
      e.pin_exp  = '0;
      e.pin_mask = '0;
      e.name     = name;
      if (do_rd) addr = a;
      exp_q.push_back(e);
      chk_req = 1'b1;
      @(negedge clk);
      chk_req = 1'b0;
   endtask

   task automatic chk_pins(input logic [W-1:0] exp, input logic [W-1:0] mask, input string name);
      chk_t e;
      e.do_rd    = 1'b0;
      e.rd_exp   = '0;
      e.do_irq   = 1'b0;
      e.irq_exp  = 1'b0;
      e.do_pin   = 1'b1;
      e.pin_exp  = exp;
      e.pin_mask = mask;
      e.name     = name;
      exp_q.push_back(e);
      chk_req = 1'b1;
      @(negedge clk);
      chk_req = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, input logic [W-1:0] exp, input string name);
      chk(1'b1, a, exp, 1'b0, 1'b0, name);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset: external drivers own every pin, DUT must stay off the bus.
      ext_oe  = '1;
      ext_val = 16'h1234;
      rst_n   = 1'b0;
      tick(2);
      chk(1'b1, GPIO_REG_DIR, 16'h0000, 1'b1, 1'b0, "rst_rdata_irq");
      chk_pins(16'h1234, 16'hFFFF, "rst_pins_hiz");
      rst_n = 1'b1;
      rd(GPIO_REG_DIR,     16'h0000, "rst_dir");
      rd(GPIO_REG_OUT,     16'h0000, "rst_out");
      rd(GPIO_REG_STAT,    16'h0000, "rst_stat");
      rd(GPIO_REG_RISE_EN, 16'h0000, "rst_rise_en");
      rd(GPIO_REG_FALL_EN, 16'h0000, "rst_fall_en");
      tick(DEB);
      chk(1'b1, GPIO_REG_IN, 16'h1234, 1'b1, 1'b0, "rst_in_irq");
      wr(3'd7, 16'hFFFF);
      wr(GPIO_REG_IN, 16'hFFFF);
      rd(3'd6, 16'h0000, "unmapped6");
      rd(3'd7, 16'h0000, "unmapped7");
      rd(GPIO_REG_DIR, 16'h0000, "ignored_writes_dir");

      // Drive: low byte from OUT, high byte from outside.
      ext_oe  = 16'hFF00;
      ext_val = 16'h3C00;
      wr(GPIO_REG_DIR, 16'h00FF);
      wr(GPIO_REG_OUT, 16'hA5A5);
      chk_pins(16'h3CA5, 16'hFFFF, "drive_pins");
      tick(3 + DEB);
      rd(GPIO_REG_IN,  16'h3CA5, "drive_in");
      rd(GPIO_REG_DIR, 16'h00FF, "drive_dir");
      rd(GPIO_REG_OUT, 16'hA5A5, "drive_out");
      wr(GPIO_REG_DIR, 16'h0000);
      ext_oe  = '1;
      ext_val = 16'h00A5;
      tick(4 + DEB);
      rd(GPIO_REG_IN, 16'h00A5, "release_in");
      ext_val = 16'h0000;
      tick(4 + DEB);
      rd(GPIO_REG_IN, 16'h0000, "idle_in");

      // Rising edge on pin0: STAT at edge 3, IRQ at edge 4 (plus debounce).
      wr(GPIO_REG_RISE_EN, 16'h0001);
      tick(2);
      ext_val[0] = 1'b1;
      tick(DEB);
      chk(1'b1, GPIO_REG_STAT, 16'h0000, 1'b1, 1'b0, "rise_e1");
      chk(1'b1, GPIO_REG_STAT, 16'h0000, 1'b1, 1'b0, "rise_e2");
      chk(1'b1, GPIO_REG_STAT, 16'h0000, 1'b1, 1'b0, "rise_e3");
      chk(1'b1, GPIO_REG_STAT, 16'h0001, 1'b1, 1'b1, "rise_e4");
      wr(GPIO_REG_STAT, 16'h0001);
      chk(1'b1, GPIO_REG_STAT, 16'h0000, 1'b1, 1'b0, "rise_clear");

      // Falling edge on pin3 captured in the same cycle as its W1C.
      ext_val[3] = 1'b1;
      tick(4 + DEB);
      wr(GPIO_REG_FALL_EN, 16'h0008);
      tick(1);
      ext_val[3] = 1'b0;
      tick(2 + DEB);
      wr(GPIO_REG_STAT, 16'h0008);
      chk(1'b1, GPIO_REG_STAT, 16'h0008, 1'b1, 1'b1, "set_beats_clear");
      wr(GPIO_REG_FALL_EN, 16'h0000);
      rd(GPIO_REG_STAT, 16'h0008, "disable_keeps_stat");
      wr(GPIO_REG_STAT, 16'h0008);
      chk(1'b1, GPIO_REG_STAT, 16'h0000, 1'b1, 1'b0, "fall_clear");

      // Masked: all enables off, pins toggle, nothing captured.
      wr(GPIO_REG_RISE_EN, 16'h0000);
      ext_val = 16'hFFFF;
      tick(4 + DEB);
      chk(1'b1, GPIO_REG_IN, 16'hFFFF, 1'b1, 1'b0, "mask_in_ffff");
      ext_val = 16'h5A5A;
      tick(4 + DEB);
      chk(1'b1, GPIO_REG_IN, 16'h5A5A, 1'b1, 1'b0, "mask_in_5a5a");
      ext_val = 16'h0000;
      tick(4 + DEB);
      chk(1'b1, GPIO_REG_STAT, 16'h0000, 1'b1, 1'b0, "mask_stat");

      // Enabling after the edge must not capture it retroactively.
      ext_val[0] = 1'b1;
      tick(4 + DEB);
      wr(GPIO_REG_RISE_EN, 16'h0001);
      tick(3);
      rd(GPIO_REG_STAT, 16'h0000, "no_retro_capture");

`ifdef GPIO_DEBOUNCE_EN
      // Debounce: 3-clock glitch rejected, 6-clock pulse accepted.
      wr(GPIO_REG_RISE_EN, 16'h0002);
      ext_val[1] = 1'b1;
      tick(3);
      ext_val[1] = 1'b0;
      tick(12);
      rd(GPIO_REG_STAT, 16'h0000, "deb_glitch_stat");
      rd(GPIO_REG_IN,   16'h0001, "deb_glitch_in");
      ext_val[1] = 1'b1;
      tick(6);
      ext_val[1] = 1'b0;
      tick(12);
      rd(GPIO_REG_STAT, 16'h0002, "deb_pulse_stat");
      wr(GPIO_REG_STAT, 16'h0002);
`endif

      // Reset in the middle of operation releases pins and clears state.
      ext_oe  = 16'hFF00;
      ext_val = 16'h1200;
      wr(GPIO_REG_DIR, 16'h00FF);
      wr(GPIO_REG_OUT, 16'h00F0);
      wr(GPIO_REG_RISE_EN, 16'h0100);
      ext_val = 16'h1300;
      tick(4 + DEB);
      chk(1'b1, GPIO_REG_STAT, 16'h0100, 1'b1, 1'b1, "pre_reset_stat_irq");
      chk_pins(16'h13F0, 16'hFFFF, "pre_reset_pins");
      rst_n = 1'b0;
      #1;
      ext_oe  = '1;
      ext_val = 16'h00C3;
      chk(1'b1, GPIO_REG_STAT, 16'h0000, 1'b1, 1'b0, "rst_mid_stat_irq");
      chk_pins(16'h00C3, 16'hFFFF, "rst_mid_pins");
      rst_n = 1'b1;
      rd(GPIO_REG_DIR,     16'h0000, "rst_mid_dir");
      rd(GPIO_REG_OUT,     16'h0000, "rst_mid_out");
      rd(GPIO_REG_RISE_EN, 16'h0000, "rst_mid_rise_en");
      tick(2 + DEB);
      rd(GPIO_REG_IN,      16'h00C3, "rst_mid_in");

      tick(2);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
